// File: rtl/rr_reg_arbiter.sv
// Round-robin arbiter feeding a single registered byte stage. One requester
// owns the output register at a time, and the register holds its byte until downstream accepts it.
module rr_reg_arbiter #(
    parameter  int unsigned N_REQ = 4,
    parameter  int unsigned DW    = 8,
    localparam int unsigned SW    = $clog2(N_REQ)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_REQ-1:0]    req_valid,
    input  logic [N_REQ*DW-1:0] req_data,
    output logic [N_REQ-1:0]    req_ready,
    output logic                out_valid,
    output logic [DW-1:0]       out_data,
    output logic [SW-1:0]       out_src,
    input  logic                out_ready,
    output logic [15:0]         grant_cnt
);

    typedef enum logic {EMPTY, FULL} state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] ptr_q, ptr_d;
    logic [SW-1:0] src_q, src_d;
    logic [DW-1:0] data_q, data_d;
    logic [15:0]   cnt_q, cnt_d;

    logic          grant_found;
    logic [SW-1:0] grant_idx;
    logic          take;
    logic          grant;
    logic [DW-1:0] req_bytes [N_REQ];

    always_comb begin
        for (int unsigned i = 0; i < N_REQ; i++) begin
            req_bytes[i] = req_data[i*DW +: DW];
        end
    end

    // Scan from the pointer, wrapping modulo N_REQ; the first valid requester wins.
    always_comb begin
        int unsigned idx;
        idx         = 0;
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            idx = 32'(ptr_q) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (!grant_found && req_valid[idx[SW-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = idx[SW-1:0];
            end
        end
    end

    always_comb begin
        take    = (state_q == EMPTY) || out_ready;
        grant   = take && grant_found;

        req_ready = '0;
        if (grant && rst_n) begin
            req_ready[grant_idx] = 1'b1;
        end

        state_d = state_q;
        ptr_d   = ptr_q;
        src_d   = src_q;
        data_d  = data_q;
        cnt_d   = cnt_q;

        if (grant) begin
            state_d = FULL;
            data_d  = req_bytes[grant_idx];
            src_d   = grant_idx;
            ptr_d   = (grant_idx == SW'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
            cnt_d   = cnt_q + 16'd1;
        end else if (state_q == FULL && out_ready) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            ptr_q   <= '0;
            src_q   <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            src_q   <= src_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_valid = (state_q == FULL);
    assign out_data  = data_q;
    assign out_src   = src_q;
    assign grant_cnt = cnt_q;

endmodule

// File: doc/rr_reg_arbiter.md
Name: rr_reg_arbiter

Overview:
Round-robin arbiter and sequencer for the shared 8-bit registered datapath stage (din -> dout_seq).
- N requesters each present a byte with a valid/ready handshake.
- The block picks one requester per cycle, captures its byte into the single output register and holds it until downstream accepts it.
- It sits between multiple byte producers and one sequential consumer, so only one source owns the register stage in any cycle.

Parameters:
N_REQ, 4, number of requesters (2..8)
DW, 8, data width of each request and of the output register
SW, $clog2(N_REQ), width of the source index (derived, not overridable)

Ports:
clk  input  1  single system clock; all state updates on posedge clk
rst_n  input  1  reset, synchronous and active-low; sampled on posedge clk
req_valid  input  N_REQ  bit i: requester i has a byte pending
req_data  input  N_REQ*DW  byte of requester i in bits [i*DW +: DW]
req_ready  output  N_REQ  bit i: requester i's byte is taken this cycle (one-hot or zero)
out_valid  output  1  output register holds an unconsumed byte
out_data  output  DW  registered byte
out_src  output  SW  index of the requester that supplied out_data
out_ready  input  1  downstream accepts out_data this cycle
grant_cnt  output  16  total accepted grants since reset, wraps at 65535 -> 0

Behaviour:
- Reset (rst_n=0 at posedge clk): out_valid=0, out_data=0, out_src=0, grant_cnt=0, rr pointer=0 (requester 0 has top priority), FSM=EMPTY.
- Reset mid-operation discards any held byte; req_ready is 0 while rst_n=0.
- FSM states:
  - EMPTY: out_valid=0.
  - FULL: out_valid=1.
- Transfer condition: take = (state==EMPTY) || (out_ready && state==FULL).
- Grant is combinational from req_valid and the pointer:
  - Search for the first i with req_valid[i]=1, starting at the pointer and wrapping modulo N_REQ.
  - req_ready[i]=1 only for that i, and only when take=1.
- Requester rules: a requester holds req_valid and req_data stable until it sees req_ready. A requester may deassert req_valid only after its transfer.
- On a grant to i at posedge clk:
  - out_data <= req_data[i], out_src <= i, out_valid <= 1.
  - pointer <= (i+1) mod N_REQ.
  - grant_cnt <= grant_cnt+1.
  - FSM -> FULL.
- Latency: a byte granted in cycle k appears on out_data in cycle k+1. This is the same one-cycle register latency as dout_seq.
- FULL && out_ready && no req_valid: out_valid <= 0, FSM -> EMPTY. out_data and out_src keep their last value.
- FULL && !out_ready: hold all output values. req_ready stays all 0 and the pointer does not change.
- Back-to-back: in FULL with out_ready=1 and a pending request, consume and grant happen in the same cycle. Throughput is 1 byte/cycle and there is no bubble.
- Fairness:
  - A continuously requesting source waits at most N_REQ-1 grants.
  - The pointer moves only on a grant; idle cycles leave it unchanged.
- Single requester: gets every slot. The pointer still advances to i+1, which is harmless.
- grant_cnt wraps from 16'hFFFF to 0 with no flag.
- Assertions required in the bench:
  - $onehot0(req_ready).
  - req_ready[i] implies req_valid[i].
  - out_data stable while out_valid && !out_ready.

Test Plan:
1. Reset then idle: rst_n=0 for 2 cycles, then 1; no req_valid -> out_valid=0, out_data=0, req_ready=0, grant_cnt=0 throughout.
2. Single request: req_valid=4'b0100, data[2]=8'h05, out_ready=1.
   - Cycle k: req_ready=4'b0100.
   - Cycle k+1: out_valid=1, out_data=8'h05, out_src=2.
   - After the request is withdrawn: out_valid=0 next cycle.
3. Round-robin: all four valid with data 3,5,7,9 and out_ready=1 -> out_data sequence 3,5,7,9,3 on consecutive cycles, out_src 0,1,2,3,0, grant_cnt=5.
4. Backpressure: out_ready=0 for 3 cycles while FULL with 8'h07.
   - out_data stays 8'h07 and req_ready=0.
   - On release, the next byte appears 1 cycle later with no loss or duplication.
5. Fairness after gap: req 3 only granted (pointer -> 0), then req 1 and req 3 valid -> req 1 granted first, then req 3.
6. Reset mid-transfer: rst_n=0 while FULL with out_data=8'h09 -> next cycle out_valid=0, out_data=0, pointer=0, grant_cnt=0; the first grant after release goes to the lowest valid index.
